// File: rtl/video_fetch_arbiter.sv
// Shared video RAM arbiter: fixed-priority video fetch over CPU access, two-cycle
// accesses, with row/line address generation for a character-row display.
module video_fetch_arbiter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              FieldStart,
  input  logic              LineEnd,
  input  logic              Load,
  input  logic              DispActive,
  input  logic [ADDR_W-1:0] VidBase,
  input  logic [3:0]        RowRepeat,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  output logic [ADDR_W-1:0] RamAddr,
  output logic              RamCe,
  output logic              RamWe,
  output logic              CpuAck,
  output logic              VidLatch,
  output logic              Overrun
);

  typedef enum logic [2:0] {IDLE, VID1, VID2, CPU1, CPU2} state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic              cpu_start;
  logic              load_valid;
  logic [ADDR_W-1:0] vid_addr, row_start, vid_addr_inc;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic              cpu_we_q;
  logic [3:0]        line_cnt;
  logic              vid_pend, overrun_q;

  assign load_valid   = Load & DispActive;
  assign cpu_start    = (state == IDLE) && (state_nxt == CPU1);
  assign vid_addr_inc = (state == VID2) ? vid_addr + ADDR_W'(1) : vid_addr;
  assign Overrun      = overrun_q;

  // armed holds IDLE for the first edge after reset so no access starts before the second edge
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    RamAddr   = vid_addr;
    RamCe     = 1'b0;
    RamWe     = 1'b0;
    CpuAck    = 1'b0;
    VidLatch  = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (vid_pend)    state_nxt = VID1;
          else if (CpuReq) state_nxt = CPU1;
        end
      end
      VID1: begin
        RamCe     = 1'b1;
        state_nxt = VID2;
      end
      VID2: begin
        RamCe     = 1'b1;
        VidLatch  = 1'b1;
        state_nxt = IDLE;
      end
      CPU1: begin
        RamCe     = 1'b1;
        RamAddr   = cpu_addr_q;
        RamWe     = cpu_we_q;
        state_nxt = CPU2;
      end
      CPU2: begin
        RamCe     = 1'b1;
        RamAddr   = cpu_addr_q;
        RamWe     = cpu_we_q;
        CpuAck    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CPU address/write are captured on entry to CPU1 so outputs never follow inputs combinationally
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      cpu_addr_q <= '0;
      cpu_we_q   <= 1'b0;
    end else if (cpu_start) begin
      cpu_addr_q <= CpuAddr;
      cpu_we_q   <= CpuWe;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      vid_pend  <= 1'b0;
      overrun_q <= 1'b0;
    end else if (FieldStart) begin
      vid_pend  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_valid)            vid_pend <= 1'b1;
      else if (state == VID2)    vid_pend <= 1'b0;
      if (load_valid && vid_pend && (state != VID2)) overrun_q <= 1'b1;
    end
  end

  // LineEnd sees the post-increment address, so a row capture includes a fetch finishing this cycle
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      vid_addr  <= '0;
      row_start <= '0;
      line_cnt  <= '0;
    end else if (FieldStart) begin
      vid_addr  <= VidBase;
      row_start <= VidBase;
      line_cnt  <= '0;
    end else if (LineEnd) begin
      if (line_cnt == RowRepeat) begin
        line_cnt  <= '0;
        row_start <= vid_addr_inc;
        vid_addr  <= vid_addr_inc;
      end else begin
        line_cnt  <= line_cnt + 4'd1;
        vid_addr  <= row_start;
      end
    end else begin
      vid_addr <= vid_addr_inc;
    end
  end

endmodule

// File: tb/tb_video_fetch_arbiter.sv
// Directed bench for video_fetch_arbiter: reset, video fetch, CPU/video ordering,
// row repeat, overrun, FieldStart/LineEnd collision and mid-access reset.
module tb_video_fetch_arbiter;
  localparam int unsigned ADDR_W = 16;

  logic              Clk = 1'b0;
  logic              RstN, FieldStart, LineEnd, Load, DispActive;
  logic [ADDR_W-1:0] VidBase;
  logic [3:0]        RowRepeat;
  logic              CpuReq, CpuWe;
  logic [ADDR_W-1:0] CpuAddr;
  logic [ADDR_W-1:0] RamAddr;
  logic              RamCe, RamWe, CpuAck, VidLatch, Overrun;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  video_fetch_arbiter #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .RstN(RstN), .FieldStart(FieldStart), .LineEnd(LineEnd),
    .Load(Load), .DispActive(DispActive), .VidBase(VidBase), .RowRepeat(RowRepeat),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .RamAddr(RamAddr),
    .RamCe(RamCe), .RamWe(RamWe), .CpuAck(CpuAck), .VidLatch(VidLatch), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    RstN = 1'b0; FieldStart = 0; LineEnd = 0; Load = 0; DispActive = 0;
    VidBase = '0; RowRepeat = '0; CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0055;
    #12;
    n_cmp++; if ({RamAddr, RamCe, RamWe, CpuAck, VidLatch, Overrun} !== '0) begin n_bad++;
      $display("FAIL reset_outputs: got addr=%h ce=%b we=%b ack=%b latch=%b ovr=%b want all 0", RamAddr, RamCe, RamWe, CpuAck, VidLatch, Overrun); end
    @(negedge Clk); RstN = 1'b1;
    tick();
    n_cmp++; if (RamCe !== 1'b0) begin n_bad++; $display("FAIL first_edge_idle: ce=%b want 0", RamCe); end
    tick();
    n_cmp++; if ({RamCe, RamWe, RamAddr} !== {1'b1, 1'b0, 16'h0055}) begin n_bad++;
      $display("FAIL second_edge_cpu1: ce=%b we=%b addr=%h want 1 0 0055", RamCe, RamWe, RamAddr); end
    tick();
    n_cmp++; if (CpuAck !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_ack: ack=%b want 1", CpuAck); end
    CpuReq = 1'b0;
    tick();
    n_cmp++; if ({RamCe, CpuAck} !== 2'b00) begin n_bad++; $display("FAIL reset_cpu_idle: ce=%b ack=%b want 0 0", RamCe, CpuAck); end
  endtask

  task automatic test_video_fetch();
    int unsigned latches = 0;
    DispActive = 1'b1; FieldStart = 1'b1; VidBase = 16'h0400;
    tick();
    FieldStart = 1'b0;
    n_cmp++; if (RamAddr !== 16'h0400) begin n_bad++; $display("FAIL field_base: addr=%h want 0400", RamAddr); end
    for (int i = 0; i < 4; i++) begin
      Load = 1'b1; tick(); Load = 1'b0;
      tick();
      n_cmp++; if ({RamCe, RamWe, RamAddr} !== {1'b1, 1'b0, 16'(16'h0400 + i)}) begin n_bad++;
        $display("FAIL vid1_%0d: ce=%b we=%b addr=%h want 1 0 %h", i, RamCe, RamWe, RamAddr, 16'(16'h0400 + i)); end
      tick();
      n_cmp++; if ({RamAddr, VidLatch} !== {16'(16'h0400 + i), 1'b1}) begin n_bad++;
        $display("FAIL vid2_%0d: addr=%h latch=%b want %h 1", i, RamAddr, VidLatch, 16'(16'h0400 + i)); end
      latches += VidLatch;
      for (int k = 0; k < 5; k++) begin tick(); latches += VidLatch; end
    end
    n_cmp++; if (latches != 4) begin n_bad++; $display("FAIL latch_count: got %0d want 4", latches); end
    n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL no_overrun: ovr=%b want 0", Overrun); end
    n_cmp++; if (RamAddr !== 16'h0404) begin n_bad++; $display("FAIL addr_after4: addr=%h want 0404", RamAddr); end
  endtask

  task automatic test_cpu_then_video();
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 16'h1234;
    tick();
    n_cmp++; if ({RamCe, RamWe, CpuAck, RamAddr} !== {3'b110, 16'h1234}) begin n_bad++;
      $display("FAIL cpu1: ce=%b we=%b ack=%b addr=%h want 1 1 0 1234", RamCe, RamWe, CpuAck, RamAddr); end
    Load = 1'b1;
    tick();
    n_cmp++; if ({RamCe, RamWe, CpuAck, RamAddr} !== {3'b111, 16'h1234}) begin n_bad++;
      $display("FAIL cpu2: ce=%b we=%b ack=%b addr=%h want 1 1 1 1234", RamCe, RamWe, CpuAck, RamAddr); end
    Load = 1'b0; CpuReq = 1'b0; CpuWe = 1'b0;
    tick();
    n_cmp++; if ({RamCe, CpuAck} !== 2'b00) begin n_bad++; $display("FAIL cpu_idle_gap: ce=%b ack=%b want 0 0", RamCe, CpuAck); end
    tick();
    n_cmp++; if ({RamCe, RamWe, RamAddr} !== {2'b10, 16'h0404}) begin n_bad++;
      $display("FAIL vid_after_cpu: ce=%b we=%b addr=%h want 1 0 0404", RamCe, RamWe, RamAddr); end
    tick();
    n_cmp++; if (VidLatch !== 1'b1) begin n_bad++; $display("FAIL latch_after_cpu: latch=%b want 1", VidLatch); end
    tick();
    n_cmp++; if ({RamCe, Overrun} !== 2'b00) begin n_bad++; $display("FAIL after_cpu_vid: ce=%b ovr=%b want 0 0", RamCe, Overrun); end
  endtask

  task automatic test_row_repeat();
    logic [ADDR_W-1:0] exp;
    RowRepeat = 4'd11; FieldStart = 1'b1; VidBase = 16'h0400;
    tick();
    FieldStart = 1'b0;
    for (int line = 0; line < 13; line++) begin
      for (int f = 0; f < 32; f++) begin
        exp = (line < 12) ? 16'(16'h0400 + f) : 16'(16'h0420 + f);
        Load = 1'b1; tick(); Load = 1'b0;
        tick();
        n_cmp++; if ({RamCe, RamAddr} !== {1'b1, exp}) begin n_bad++;
          $display("FAIL row_fetch l%0d f%0d: ce=%b addr=%h want 1 %h", line, f, RamCe, RamAddr, exp); end
        tick(); tick();
      end
      LineEnd = 1'b1; tick(); LineEnd = 1'b0;
    end
    n_cmp++; if (RamAddr !== 16'h0420) begin n_bad++; $display("FAIL row_rewind: addr=%h want 0420", RamAddr); end
  endtask

  task automatic test_overrun();
    int unsigned latches = 0;
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0ABC;
    tick();
    n_cmp++; if ({RamCe, RamWe, RamAddr} !== {2'b10, 16'h0ABC}) begin n_bad++;
      $display("FAIL ovr_cpu1: ce=%b we=%b addr=%h want 1 0 0abc", RamCe, RamWe, RamAddr); end
    Load = 1'b1;
    tick();
    CpuReq = 1'b0;
    tick();
    Load = 1'b0;
    n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: ovr=%b want 1", Overrun); end
    for (int k = 0; k < 8; k++) begin tick(); latches += VidLatch; end
    n_cmp++; if (latches != 1) begin n_bad++; $display("FAIL overrun_single_fetch: got %0d want 1", latches); end
    n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: ovr=%b want 1", Overrun); end
    FieldStart = 1'b1; VidBase = 16'h0400;
    tick();
    FieldStart = 1'b0;
    n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: ovr=%b want 0", Overrun); end
  endtask

  task automatic test_field_line_same();
    RowRepeat = 4'd11;
    LineEnd = 1'b1; tick(); LineEnd = 1'b0;
    n_cmp++; if (dut.line_cnt !== 4'd1) begin n_bad++; $display("FAIL line_cnt_pre: got %0d want 1", dut.line_cnt); end
    FieldStart = 1'b1; LineEnd = 1'b1; VidBase = 16'h0800;
    tick();
    FieldStart = 1'b0; LineEnd = 1'b0;
    n_cmp++; if (RamAddr !== 16'h0800) begin n_bad++; $display("FAIL fs_le_addr: addr=%h want 0800", RamAddr); end
    n_cmp++; if (dut.line_cnt !== 4'd0) begin n_bad++; $display("FAIL fs_le_linecnt: got %0d want 0", dut.line_cnt); end
  endtask

  task automatic test_reset_mid_access();
    Load = 1'b1; tick(); Load = 1'b0;
    tick();
    n_cmp++; if ({RamCe, RamAddr} !== {1'b1, 16'h0800}) begin n_bad++;
      $display("FAIL mid_vid1: ce=%b addr=%h want 1 0800", RamCe, RamAddr); end
    #1; RstN = 1'b0; #1;
    n_cmp++; if ({RamAddr, RamCe, RamWe, CpuAck, VidLatch, Overrun} !== '0) begin n_bad++;
      $display("FAIL mid_reset_outputs: addr=%h ce=%b we=%b ack=%b latch=%b ovr=%b want all 0", RamAddr, RamCe, RamWe, CpuAck, VidLatch, Overrun); end
    tick();
    n_cmp++; if ({RamCe, VidLatch} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_hold: ce=%b latch=%b want 0 0", RamCe, VidLatch); end
    RstN = 1'b1;
    tick();
    n_cmp++; if ({RamCe, VidLatch, RamAddr} !== '0) begin n_bad++;
      $display("FAIL post_reset_idle: ce=%b latch=%b addr=%h want 0 0 0000", RamCe, VidLatch, RamAddr); end
    tick(); tick();
    n_cmp++; if ({RamCe, VidLatch} !== 2'b00) begin n_bad++; $display("FAIL post_reset_no_fetch: ce=%b latch=%b want 0 0", RamCe, VidLatch); end
  endtask

  initial begin
    test_reset();
    test_video_fetch();
    test_cpu_then_video();
    test_row_repeat();
    test_overrun();
    test_field_line_same();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
